// File: rtl/fifo_wr_ptr_ctrl_pkg.sv
// fifo_wr_ptr_ctrl_pkg: shared pointer types, sizing constants and Gray conversions for the async FIFO.
package DataTypes;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  typedef logic bit_t;
  typedef logic [PTR_W-1:0] ADDR_W;
  // Conversions are done at 32 bits so any pointer width can use them by zero-extending and truncating.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction
endpackage

// File: rtl/fifo_wr_ptr_ctrl.sv
// fifo_wr_ptr_ctrl: write-domain pointer, RAM strobe and full/almost-full/level flags of the async FIFO.
module fifo_wr_ptr_ctrl
  import DataTypes::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [PW-1:0] r_wbin;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin_s;
  logic [PW-1:0] w_diff;
  logic [PW-1:0] w_full_cmp;
  bit_t          w_push;
  assign w_push       = wr_en & ~full & reset;
  assign mem_we       = w_push;
  assign wr_addr      = r_wbin[ADDR_WIDTH-1:0];
  assign w_wbin_next  = r_wbin + PW'(w_push);
  assign w_wgray_next = PW'(bin2gray(32'(w_wbin_next)));
  assign w_rbin_s     = PW'(gray2bin(32'(rptr_gray_sync)));
  assign w_diff       = w_wbin_next - w_rbin_s;
  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign w_full_cmp   = {~rptr_gray_sync[PW-1:PW-2], rptr_gray_sync[PW-3:0]};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wbin      <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      wptr_gray   <= w_wgray_next;
      full        <= (w_wgray_next == w_full_cmp);
      almost_full <= (w_diff >= PW'(AFULL_THRESH));
      wr_level    <= w_diff;
      overflow    <= wr_en & full;
    end
  end
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// tb_fifo_wr_ptr_ctrl: scoreboard bench driving directed and random pushes/reader motion against a count-based model.
module tb_fifo_wr_ptr_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] rptr_gray_sync = '0;
  logic [3:0] wr_addr;
  logic       mem_we;
  logic [4:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  fifo_wr_ptr_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rptr_gray_sync(rptr_gray_sync),
    .wr_addr(wr_addr), .mem_we(mem_we), .wptr_gray(wptr_gray), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int we; int addr; int full; int af; int lvl; int gray; int ovf;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_wc = 0;
  int m_rc = 0;
  int m_full = 0;
  int prev_gray = 0;

  function automatic int g(input int n);
    return (n ^ (n >> 1)) & 31;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts of total pushes and reads; occupancy is their difference.
  task automatic cycle(input bit we, input int rc);
    exp_t e;
    int lvl;
    @(negedge clk);
    m_rc = rc;
    wr_en = we;
    rptr_gray_sync = 5'(g(m_rc % 32));
    e.we = (we && !m_full) ? 1 : 0;
    e.addr = m_wc % 16;
    e.ovf = (we && m_full) ? 1 : 0;
    if (e.we == 1) m_wc++;
    lvl = m_wc - m_rc;
    m_full = (lvl == 16) ? 1 : 0;
    e.full = m_full;
    e.af = (lvl >= 12) ? 1 : 0;
    e.lvl = lvl;
    e.gray = g(m_wc % 32);
    exp_q.push_back(e);
  endtask

  task automatic reader_step(output int rc);
    rc = m_rc + ((($urandom % 2) == 1 && m_rc < m_wc) ? 1 : 0);
  endtask

  initial begin : monitor
    int s_we, s_addr;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      s_we = int'(mem_we);
      s_addr = int'(wr_addr);
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_we", s_we, e.we);
        if (e.we == 1) chk("wr_addr", s_addr, e.addr);
        chk("full", int'(full), e.full);
        chk("almost_full", int'(almost_full), e.af);
        chk("wr_level", int'(wr_level), e.lvl);
        chk("wptr_gray", int'(wptr_gray), e.gray);
        chk("overflow", int'(overflow), e.ovf);
        chk("gray_one_bit", ($countones(5'(prev_gray) ^ wptr_gray) <= 1) ? 1 : 0, 1);
        prev_gray = int'(wptr_gray);
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_af"}, int'(almost_full), 0);
    chk({tag, "_level"}, int'(wr_level), 0);
    chk({tag, "_gray"}, int'(wptr_gray), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_addr"}, int'(wr_addr), 0);
    chk({tag, "_we"}, int'(mem_we), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #3;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: timeout reached, expected simulation end");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int rc;
    wr_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_cleared("reset");
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) cycle(1'b1, 0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 0);
    cycle(1'b0, 4);
    cycle(1'b0, 5);
    for (int i = 0; i < 300; i++) begin
      reader_step(rc);
      cycle(($urandom % 10) < 7, rc);
    end
    for (int i = 0; i < 60; i++) cycle(1'b1, m_rc);
    for (int i = 0; i < 60; i++) begin
      reader_step(rc);
      cycle(1'b0, rc);
    end
    drain();
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_wc = 0; m_rc = 0; m_full = 0; prev_gray = 0;
    rptr_gray_sync = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) cycle(1'b1, 0);
    drain();
    wr_en = 1'b1;
    reset = 1'b0;
    #1;
    check_cleared("async_rst");
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("post_rst_level", int'(wr_level), 0);
    chk("post_rst_addr", int'(wr_addr), 0);
    m_wc = 0; m_rc = 0; m_full = 0; prev_gray = 0;
    for (int i = 0; i < 80; i++) begin
      reader_step(rc);
      cycle(($urandom % 10) < 8, rc);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
